// File: rtl/snn_pkg.sv
// Shared widths, sweep FSM states and fixed-point helpers for the LIF update engine.
package snn_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 14;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CALC,
      S_WRITE,
      S_DONE
   } state_t;

   function automatic logic signed [DATA_W+1:0] sext18(input logic signed [DATA_W-1:0] x);
      return $signed({{2{x[DATA_W-1]}}, x});
   endfunction

   // Clamp an 18-bit intermediate sum back into the 16-bit signed potential range.
   function automatic logic signed [DATA_W-1:0] sat18(input logic signed [DATA_W+1:0] s);
      if (s > 18'sd32767) begin
         return 16'sh7FFF;
      end else if (s < -18'sd32768) begin
         return 16'sh8000;
      end else begin
         return s[DATA_W-1:0];
      end
   endfunction

endpackage

// File: rtl/lif_neuron_alu.sv
// Combinational per-neuron update: leak, integrate, saturate, threshold.
// Written value is V_RESET on a spike, otherwise the saturated potential.
module lif_neuron_alu
   import snn_pkg::*;
#(
   parameter int                         LEAK_SHIFT = 4,
   parameter logic signed [DATA_W-1:0]   THRESHOLD  = 16'sd4096,
   parameter logic signed [DATA_W-1:0]   V_RESET    = 16'sd0
) (
   input  logic [DATA_W-1:0] v_in,
   input  logic [DATA_W-1:0] current,
   output logic [DATA_W-1:0] wr_val,
   output logic              spike
);

   logic signed [DATA_W-1:0] v_s;
   logic signed [DATA_W-1:0] cur_s;
   logic signed [DATA_W-1:0] leak;
   logic signed [DATA_W-1:0] v_sat;
   logic signed [DATA_W+1:0] sum;

   always_comb begin
      v_s    = $signed(v_in);
      cur_s  = $signed(current);
      leak   = v_s >>> LEAK_SHIFT;
      // 18 bits holds the worst case of two full-scale operands plus the leak term.
      sum    = sext18(v_s) - sext18(leak) + sext18(cur_s);
      v_sat  = sat18(sum);
      spike  = (v_sat >= THRESHOLD);
      wr_val = spike ? V_RESET : v_sat;
   end

endmodule

// File: rtl/lif_update_engine.sv
// Timestep sweep over the neuron-state RAM: READ, CALC, WRITE per neuron (3 cycles unstalled).
// CALC holds until an input current arrives and, on a spike, until the one-entry spike buffer is free.
module lif_update_engine
   import snn_pkg::*;
#(
   parameter int                         N_NEURONS  = 1024,
   parameter int                         LEAK_SHIFT = 4,
   parameter logic signed [DATA_W-1:0]   THRESHOLD  = 16'sd4096,
   parameter logic signed [DATA_W-1:0]   V_RESET    = 16'sd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_current,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_d,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q,
   output logic              spike_valid,
   input  logic              spike_ready,
   output logic [ADDR_W-1:0] spike_idx
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] v_reg;
   logic [DATA_W-1:0] alu_val;
   logic              alu_spike;
   logic              spike_drain;
   logic              advance;

   lif_neuron_alu #(
      .LEAK_SHIFT (LEAK_SHIFT),
      .THRESHOLD  (THRESHOLD),
      .V_RESET    (V_RESET)
   ) u_alu (
      .v_in    (ram_q),
      .current (in_current),
      .wr_val  (alu_val),
      .spike   (alu_spike)
   );

   assign spike_drain = spike_valid & spike_ready;
   // A spiking neuron may only leave CALC if its event has somewhere to go this cycle.
   assign advance     = (state == S_CALC) & in_valid &
                        (~alu_spike | ~spike_valid | spike_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         v_reg       <= '0;
         spike_valid <= 1'b0;
         spike_idx   <= '0;
      end else begin
         if (spike_drain) begin
            spike_valid <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               idx <= '0;
               if (start) begin
                  state <= S_READ;
               end
            end
            S_READ: begin
               state <= S_CALC;
            end
            S_CALC: begin
               if (advance) begin
                  v_reg <= alu_val;
                  if (alu_spike) begin
                     spike_valid <= 1'b1;
                     spike_idx   <= idx;
                  end
                  state <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (idx == LAST_IDX) begin
                  state <= S_DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= S_READ;
               end
            end
            S_DONE: begin
               idx   <= '0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // The address is held through CALC so the registered RAM keeps returning the same word.
   assign busy        = (state == S_READ) | (state == S_CALC) | (state == S_WRITE);
   assign done        = (state == S_DONE);
   assign in_ready    = (state == S_CALC);
   assign ram_we      = (state == S_WRITE);
   assign ram_address = idx;
   assign ram_d       = v_reg;

endmodule

// File: tb/tb_lif_update_engine.sv
// Directed bench for lif_update_engine with a 4-neuron sweep and a behavioural registered-read RAM.
module tb_lif_update_engine;
   import snn_pkg::*;

   localparam int N = 4;

   logic              clk;
   logic              rst;
   logic              start;
   logic              busy;
   logic              done;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_current;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_d;
   logic              ram_we;
   logic [DATA_W-1:0] ram_q;
   logic              spike_valid;
   logic              spike_ready;
   logic [ADDR_W-1:0] spike_idx;

   lif_update_engine #(
      .N_NEURONS  (N),
      .LEAK_SHIFT (4),
      .THRESHOLD  (16'sd4096),
      .V_RESET    (16'sd0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_current  (in_current),
      .ram_address (ram_address),
      .ram_d       (ram_d),
      .ram_we      (ram_we),
      .ram_q       (ram_q),
      .spike_valid (spike_valid),
      .spike_ready (spike_ready),
      .spike_idx   (spike_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem [0:N-1];
   logic [DATA_W-1:0] pre [0:N-1];
   logic              preload;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < N; i++) mem[i] <= pre[i];
      end else if (ram_we) begin
         mem[ram_address[1:0]] <= ram_d;
      end
      ram_q <= ram_we ? ram_d : mem[ram_address[1:0]];
   end

   int          acc_cnt = 0;
   logic [13:0] acc_log [0:63];

   always @(posedge clk) begin
      if (!rst && spike_valid && spike_ready) begin
         acc_log[acc_cnt[5:0]] <= spike_idx;
         acc_cnt <= acc_cnt + 1;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load(input int v0, input int v1, input int v2, input int v3);
      pre[0] = 16'(v0);
      pre[1] = 16'(v1);
      pre[2] = 16'(v2);
      pre[3] = 16'(v3);
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
   endtask

   // Starts a sweep and counts periods after the start edge (period 1 = first READ).
   task automatic run_sweep(input int stall_n, input int ready_at, input int start_pulse_at,
                            output int done_at, output int spk_at, output int spk_idx0,
                            output int stall_bad);
      int  stall_left;
      bit  prev_low;
      stall_left = stall_n;
      prev_low   = 1'b0;
      done_at    = -1;
      spk_at     = -1;
      spk_idx0   = -1;
      stall_bad  = 0;
      in_valid   = 1'b1;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 300 && done_at < 0; k++) begin
         @(negedge clk);
         if (spike_valid && spk_at < 0) begin
            spk_at   = k;
            spk_idx0 = int'(spike_idx);
         end
         if (done) done_at = k;
         if (prev_low && !(in_ready && ram_address == 14'd1 && !ram_we)) stall_bad++;
         if (stall_left > 0 && in_ready && ram_address == 14'd1) begin
            in_valid = 1'b0;
            stall_left--;
            prev_low = 1'b1;
         end else begin
            in_valid = 1'b1;
            prev_low = 1'b0;
         end
         if (k == ready_at) spike_ready = 1'b1;
         start = (k == start_pulse_at);
      end
      start    = 1'b0;
      in_valid = 1'b1;
      if (done_at < 0) check("sweep_timeout", 0, 1);
   endtask

   typedef struct {
      int init;
      int cur;
      int exp_v;
      int exp_spk;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int d, sa, si, sb, base, seen;

      vecs[0] = '{1600,   100,    1600,   0};
      vecs[1] = '{4000,   400,    0,      1};
      vecs[2] = '{-32000, -32768, -32768, 0};
      vecs[3] = '{32767,  32767,  0,      1};
      vecs[4] = '{0,      4096,   0,      1};
      vecs[5] = '{0,      4095,   4095,   0};
      vecs[6] = '{-100,   0,      -93,    0};

      rst         = 1'b1;
      start       = 1'b0;
      in_valid    = 1'b0;
      in_current  = '0;
      spike_ready = 1'b1;
      preload     = 1'b0;
      for (int i = 0; i < N; i++) pre[i] = '0;
      @(negedge clk);
      do_reset();

      check("rst_busy",        int'(busy),        0);
      check("rst_done",        int'(done),        0);
      check("rst_in_ready",    int'(in_ready),    0);
      check("rst_ram_we",      int'(ram_we),      0);
      check("rst_ram_address", int'(ram_address), 0);
      check("rst_ram_d",       int'(ram_d),       0);
      check("rst_spike_valid", int'(spike_valid), 0);
      check("rst_spike_idx",   int'(spike_idx),   0);

      // Uniform-memory table: every neuron gets the same start value and current.
      for (int v = 0; v < 7; v++) begin
         do_reset();
         load(vecs[v].init, vecs[v].init, vecs[v].init, vecs[v].init);
         in_current  = 16'(vecs[v].cur);
         spike_ready = 1'b1;
         base = acc_cnt;
         run_sweep(0, 0, 0, d, sa, si, sb);
         check($sformatf("vec%0d_done_at", v), d, 13);
         check($sformatf("vec%0d_mem0", v), int'($signed(mem[0])), vecs[v].exp_v);
         check($sformatf("vec%0d_mem3", v), int'($signed(mem[3])), vecs[v].exp_v);
         check($sformatf("vec%0d_spikes", v), acc_cnt - base, vecs[v].exp_spk * 4);
      end

      // Single spike at neuron 2: event visible in its WRITE period.
      do_reset();
      load(1600, 1600, 4000, 1600);
      in_current  = 16'd400;
      spike_ready = 1'b1;
      run_sweep(0, 0, 0, d, sa, si, sb);
      check("spk2_at",       sa, 9);
      check("spk2_idx",      si, 2);
      check("spk2_done_at",  d, 13);
      check("spk2_mem2",     int'($signed(mem[2])), 0);
      check("spk2_mem1",     int'($signed(mem[1])), 1900);

      // in_valid withheld five CALC cycles at neuron 1.
      do_reset();
      load(1600, 1600, 1600, 1600);
      in_current  = 16'd100;
      spike_ready = 1'b1;
      run_sweep(5, 0, 0, d, sa, si, sb);
      check("stall_done_at", d, 18);
      check("stall_hold",    sb, 0);
      check("stall_mem1",    int'($signed(mem[1])), 1600);

      // Two spikes, downstream not ready until period 10; start pulse while busy ignored.
      do_reset();
      load(4000, 4000, 1600, 1600);
      in_current  = 16'd400;
      spike_ready = 1'b0;
      base = acc_cnt;
      run_sweep(0, 10, 7, d, sa, si, sb);
      check("bp_first_spk_at", sa, 3);
      check("bp_first_idx",    si, 0);
      check("bp_done_at",      d, 18);
      check("bp_accepted",     acc_cnt - base, 2);
      check("bp_acc0",         int'(acc_log[base[5:0]]), 0);
      check("bp_acc1",         int'(acc_log[6'(base + 1)]), 1);
      check("bp_mem1",         int'($signed(mem[1])), 0);
      check("bp_mem2",         int'($signed(mem[2])), 1900);
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (busy) seen++;
      end
      check("bp_no_resweep", seen, 0);

      // Reset in the middle of a backpressured sweep, then a fresh sweep.
      do_reset();
      load(4000, 4000, 4000, 4000);
      in_current  = 16'd400;
      in_valid    = 1'b1;
      spike_ready = 1'b0;
      start       = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (7) @(negedge clk);
      check("mid_spike_pending", int'(spike_valid), 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_busy",        int'(busy),        0);
      check("mid_rst_spike_valid", int'(spike_valid), 0);
      check("mid_rst_ram_address", int'(ram_address), 0);
      check("mid_rst_ram_we",      int'(ram_we),      0);
      check("mid_rst_in_ready",    int'(in_ready),    0);
      @(negedge clk);
      rst = 1'b0;
      check("mid_mem0_kept", int'($signed(mem[0])), 0);
      check("mid_mem1_kept", int'($signed(mem[1])), 4000);
      spike_ready = 1'b1;
      start       = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("post_rst_addr", int'(ram_address), 0);
      check("post_rst_busy", int'(busy), 1);
      d = -1;
      for (int k = 2; k <= 60 && d < 0; k++) begin
         @(negedge clk);
         if (done) d = k;
      end
      check("post_rst_done_at", d, 13);
      check("post_rst_mem1",    int'($signed(mem[1])), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/lif_update_engine.md
# lif_update_engine

Per-timestep leaky-integrate-and-fire sweep controller that owns the port of the 16-bit neuron-state RAM (14-bit address, one-cycle registered read, write-first-cycle `we`). On each `start` it walks neuron indices 0..N_NEURONS-1 and, for each, reads the membrane potential, applies leak, integrates one input current from the synapse stage, thresholds, and writes back. Threshold crossings are emitted as neuron-index spike events to the downstream spike router.

## Interface
- N_NEURONS, 1024: neurons swept per timestep; range 1..16384.
- ADDR_W, 14: RAM address width.
- DATA_W, 16: potential/current width, two's complement.
- LEAK_SHIFT, 4: leak = v >>> LEAK_SHIFT (arithmetic).
- THRESHOLD, 16'sd4096: spike when updated v >= THRESHOLD (signed).
- V_RESET, 16'sd0: potential written after a spike.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sweep; sampled only in IDLE.
- busy  out  1  high from first READ through last WRITE.
- done  out  1  one-cycle pulse after last WRITE.
- in_valid  in  1  in_current valid.
- in_ready  out  1  high only in CALC; transfer on in_valid & in_ready.
- in_current  in  16  signed current for current index.
- ram_address  out  14  RAM address.
- ram_d  out  16  write data.
- ram_we  out  1  write enable.
- ram_q  in  16  RAM read data (valid one cycle after address).
- spike_valid  out  1  spike event pending.
- spike_ready  in  1  downstream accepts on spike_valid & spike_ready.
- spike_idx  out  14  index of spiking neuron.

## Operation
- States: IDLE, READ, CALC, WRITE, DONE.
- IDLE: idx=0; start -> READ. start while not IDLE ignored.
- READ: ram_address=idx, ram_we=0 -> CALC.
- CALC: ram_address held at idx, ram_we=0 (keeps ram_q stable); in_ready=1. Advance only on input transfer AND (no spike OR spike buffer empty or draining this cycle); else stay. On advance register v_next; if spike, load spike_idx=idx, set spike_valid -> WRITE.
- Update: s = sext18(q) - sext18(q>>>LEAK_SHIFT) + sext18(in_current); v = clamp(s, -32768, 32767); spike = (v >= THRESHOLD); written value = spike ? V_RESET : v.
- WRITE: ram_address=idx, ram_we=1, ram_d=written value. If idx==N_NEURONS-1 -> DONE, else idx+1, -> READ.
- DONE: done=1 one cycle -> IDLE.
- Spike buffer: one entry; spike_valid clears on acceptance; holds across sweeps and into IDLE until accepted.
- rst mid-sweep: immediate return to IDLE, idx=0, spike buffer cleared; RAM keeps partially updated contents (no rollback).

## Timing
- Reset values: busy=0, done=0, in_ready=0, ram_we=0, ram_address=0, ram_d=0, spike_valid=0, spike_idx=0.
- Outputs decoded from registered state/idx/v only; no input-to-output combinational path except none (in_ready depends on state only).
- start sampled cycle s: READ idx0 at s+1, CALC s+2, WRITE s+3; 3 cycles/neuron without stalls.
- Unstalled sweep: last WRITE at s+3·N, done at s+3·N+1, busy high s+1..s+3·N.
- spike_valid rises cycle of the WRITE for that neuron.

## Structure
- Package snn_pkg: DATA_W/ADDR_W constants, state enum type, 18-bit saturate-to-16 function.
- Sub-module lif_neuron_alu: combinational leak, integrate, saturate, threshold compare; outputs written value and spike flag.

## Test plan
- Reset: assert rst 2 cycles mid-sweep -> all outputs at reset values next cycle, start after release sweeps from idx 0.
- N=4, mem[0..3]=1600, in_current=100 always valid -> each written 1600 (1600-100+100), no spikes, done at s+13.
- mem[2]=4000, in_current=400 -> s=4150 >= 4096, spike_idx=2 valid at s+9, mem[2]=0.
- mem[1]=-32000, in_current=-32768 -> s=-62768 clamped, mem[1]=-32768, no spike.
- in_valid low 5 cycles in CALC for idx 1 -> ram_address stays 1, ram_we stays 0, done delayed by 5 cycles.
- Two spikes with spike_ready low -> second CALC stalls until first accepted; start pulsed while busy ignored.
